// File: rtl/mp3dec_pkg.sv
// Shared encodings for the MP3 decoder stream controller: FSM states,
// register indices and bit positions within CTRL and INT_STAT.
package mp3dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_ASSERT = 3'd1,
    ST_RST_WAIT   = 3'd2,
    ST_READY      = 3'd3,
    ST_RUN        = 3'd4
  } state_t;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_THRESH   = 3'd2;
  localparam logic [2:0] REG_INT_STAT = 3'd3;
  localparam logic [2:0] REG_INT_EN   = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_SRST  = 2;

  localparam int INT_W           = 4;
  localparam int INT_IFIFO_LOW   = 0;
  localparam int INT_OFIFO_HIGH  = 1;
  localparam int INT_RST_DONE    = 2;
  localparam int INT_RST_TIMEOUT = 3;

endpackage

// File: rtl/mp3dec_wm_irq.sv
// FIFO watermark requests, their rising-edge interrupts, and the
// INT_STAT / INT_EN / irq registers.
module mp3dec_wm_irq
  import mp3dec_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             run,
  input  logic [CNT_W-1:0] ififo_cnt,
  input  logic [CNT_W-1:0] ofifo_cnt,
  input  logic [CNT_W-1:0] ififo_th,
  input  logic [CNT_W-1:0] ofifo_th,
  input  logic             rst_done_set,
  input  logic             rst_to_set,
  input  logic [INT_W-1:0] int_clr,
  input  logic             int_en_we,
  input  logic [INT_W-1:0] int_en_wdata,
  output logic [INT_W-1:0] int_stat,
  output logic [INT_W-1:0] int_en,
  output logic             ififo_req,
  output logic             ofifo_req,
  output logic             irq
);

  logic             ififo_hit, ofifo_hit;
  logic [INT_W-1:0] int_set;

  always_comb begin
    ififo_hit = run && (ififo_cnt <= ififo_th);
    ofifo_hit = run && (ofifo_cnt >= ofifo_th);
    // Request edges are taken against the registered request, so the
    // interrupt bit updates on the same edge the request rises.
    int_set                  = '0;
    int_set[INT_IFIFO_LOW]   = ififo_hit & ~ififo_req;
    int_set[INT_OFIFO_HIGH]  = ofifo_hit & ~ofifo_req;
    int_set[INT_RST_DONE]    = rst_done_set;
    int_set[INT_RST_TIMEOUT] = rst_to_set;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ififo_req <= 1'b0;
      ofifo_req <= 1'b0;
      int_stat  <= '0;
      int_en    <= '0;
      irq       <= 1'b0;
    end else begin
      ififo_req <= ififo_hit;
      ofifo_req <= ofifo_hit;
      // Hardware set wins over a simultaneous W1C.
      int_stat  <= (int_stat & ~int_clr) | int_set;
      if (int_en_we) int_en <= int_en_wdata;
      irq       <= |(int_stat & int_en);
    end
  end

endmodule

// File: rtl/mp3dec_stream_ctrl.sv
// Decoder reset/enable sequencer with a single-cycle register port;
// watermark and interrupt logic lives in mp3dec_wm_irq.
module mp3dec_stream_ctrl
  import mp3dec_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int RST_CYCLES  = 16,
  parameter int RST_TIMEOUT = 1023
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             reg_sel,
  input  logic             reg_wr,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  input  logic [CNT_W-1:0] ififo_cnt,
  input  logic [CNT_W-1:0] ofifo_cnt,
  input  logic             ififo_rst_busy,
  input  logic             ofifo_rst_busy,
  output logic             dec_rst,
  output logic             dec_en,
  output logic             ififo_req,
  output logic             ofifo_req,
  output logic             irq
);

  localparam int CNT_MAX = (RST_TIMEOUT > RST_CYCLES) ? RST_TIMEOUT : RST_CYCLES;
  localparam int CTR_W   = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               done_set, to_set;
  logic [CNT_W-1:0]   ififo_th, ofifo_th;
  logic [INT_W-1:0]   int_stat, int_en, int_clr;
  logic [31:0]        rd_mux;
  logic               wr_ctrl, wr_thresh, wr_int_stat, wr_int_en;
  logic               start, stop, srst;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;

  always_comb begin
    wr_ctrl     = reg_sel && reg_wr && (reg_addr == REG_CTRL);
    wr_thresh   = reg_sel && reg_wr && (reg_addr == REG_THRESH);
    wr_int_stat = reg_sel && reg_wr && (reg_addr == REG_INT_STAT);
    wr_int_en   = reg_sel && reg_wr && (reg_addr == REG_INT_EN);
    start       = wr_ctrl && reg_wdata[CTRL_START];
    stop        = wr_ctrl && reg_wdata[CTRL_STOP];
    srst        = wr_ctrl && reg_wdata[CTRL_SRST];
    int_clr     = wr_int_stat ? reg_wdata[INT_W-1:0] : '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    done_set = 1'b0;
    to_set   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        pend_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_RST_ASSERT;
      end
      ST_RST_ASSERT: begin
        if (cnt_q == CTR_W'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_RST_WAIT;
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      ST_RST_WAIT: begin
        if (!ififo_rst_busy && !ofifo_rst_busy) begin
          done_set = 1'b1;
          pend_d   = 1'b0;
          state_d  = pend_q ? ST_RUN : ST_READY;
        end else if (cnt_q == CTR_W'(RST_TIMEOUT - 1)) begin
          to_set  = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CTR_W'(1);
        end
      end
      ST_READY: if (start) state_d = ST_RUN;
      ST_RUN:   if (stop)  state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase
    // Soft reset overrides everything, including a completing wait.
    if (srst) begin
      state_d  = ST_RST_ASSERT;
      cnt_d    = '0;
      pend_d   = 1'b0;
      done_set = 1'b0;
      to_set   = 1'b0;
    end
  end

  // dec_rst/dec_en are flopped from the next state so they leave glitch-free.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dec_rst <= 1'b1;
      dec_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dec_rst <= (state_d == ST_IDLE) || (state_d == ST_RST_ASSERT);
      dec_en  <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_STATUS: begin
        rd_mux[2:0] = state_q;
        rd_mux[3]   = pend_q;
      end
      REG_THRESH: begin
        rd_mux[CNT_W-1:0]  = ififo_th;
        rd_mux[16+:CNT_W]  = ofifo_th;
      end
      REG_INT_STAT: rd_mux[INT_W-1:0] = int_stat;
      REG_INT_EN:   rd_mux[INT_W-1:0] = int_en;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      reg_rdata <= '0;
      ififo_th  <= '0;
      ofifo_th  <= '0;
    end else begin
      if (reg_sel && !reg_wr) reg_rdata <= rd_mux;
      if (wr_thresh) begin
        ififo_th <= reg_wdata[CNT_W-1:0];
        ofifo_th <= reg_wdata[16+:CNT_W];
      end
    end
  end

  mp3dec_wm_irq #(.CNT_W(CNT_W)) u_wm_irq (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .run          (state_q == ST_RUN),
    .ififo_cnt    (ififo_cnt),
    .ofifo_cnt    (ofifo_cnt),
    .ififo_th     (ififo_th),
    .ofifo_th     (ofifo_th),
    .rst_done_set (done_set),
    .rst_to_set   (to_set),
    .int_clr      (int_clr),
    .int_en_we    (wr_int_en),
    .int_en_wdata (reg_wdata[INT_W-1:0]),
    .int_stat     (int_stat),
    .int_en       (int_en),
    .ififo_req    (ififo_req),
    .ofifo_req    (ofifo_req),
    .irq          (irq)
  );

endmodule

// File: tb/tb_mp3dec_stream_ctrl.sv
// Directed bench for mp3dec_stream_ctrl: sequencing, watermarks, interrupts, resets.
module tb_mp3dec_stream_ctrl;

  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_THRESH = 3'd2,
                         A_INT_STAT = 3'd3, A_INT_EN = 3'd4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        reg_sel, reg_wr;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [9:0]  ififo_cnt, ofifo_cnt;
  logic        ififo_rst_busy, ofifo_rst_busy;
  logic        dec_rst, dec_en, ififo_req, ofifo_req, irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] rv;
  int n;

  always #5 HCLK = ~HCLK;

  mp3dec_stream_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .ififo_cnt(ififo_cnt), .ofifo_cnt(ofifo_cnt),
    .ififo_rst_busy(ififo_rst_busy), .ofifo_rst_busy(ofifo_rst_busy),
    .dec_rst(dec_rst), .dec_en(dec_en),
    .ififo_req(ififo_req), .ofifo_req(ofifo_req), .irq(irq)
  );

  // All drivers return 1 time unit after a rising edge.
  task automatic step(input int k);
    repeat (k) begin @(posedge HCLK); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge HCLK); #1;
    reg_sel = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = a;
    @(posedge HCLK); #1;
    reg_sel = 1'b0;
    d = reg_rdata;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; reg_sel = 0; reg_wr = 0; reg_addr = '0; reg_wdata = '0;
    ififo_cnt = 10'h041; ofifo_cnt = 10'h000;
    ififo_rst_busy = 0; ofifo_rst_busy = 0;
    #12;
    checks++; if (dec_rst !== 1'b1) begin errors++; $display("FAIL reset_dec_rst got=%b exp=1", dec_rst); end
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL reset_dec_en got=%b exp=0", dec_en); end
    checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
    checks++; if ({ififo_req, ofifo_req, irq} !== 3'b000) begin errors++; $display("FAIL reset_req_irq got=%b exp=000", {ififo_req, ofifo_req, irq}); end
    @(posedge HCLK); #1; HRESETn = 1'b1;
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", rv); end
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_int_stat got=%h exp=0", rv); end
    rd(A_THRESH, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_thresh got=%h exp=0", rv); end
  endtask

  task automatic test_regs;
    wr(A_THRESH, 32'hFFFF_FFFF);
    rd(A_THRESH, rv);
    checks++; if (rv !== 32'h03FF_03FF) begin errors++; $display("FAIL thresh_trunc got=%h exp=03ff03ff", rv); end
    wr(A_THRESH, 32'h0100_0040);
    rd(A_THRESH, rv);
    checks++; if (rv !== 32'h0100_0040) begin errors++; $display("FAIL thresh_rw got=%h exp=01000040", rv); end
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", rv); end
    rd(A_CTRL, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL ctrl_rd got=%h exp=0", rv); end
  endtask

  task automatic test_start;
    wr(A_CTRL, 32'h1);
    checks++; if ({dec_rst, dec_en} !== 2'b10) begin errors++; $display("FAIL start_rst_assert got=%b exp=10", {dec_rst, dec_en}); end
    n = 0;
    while (dec_rst === 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL rst_assert_len got=%0d exp=16", n); end
    step(1);
    checks++; if (dec_en !== 1'b1) begin errors++; $display("FAIL start_dec_en got=%b exp=1", dec_en); end
    checks++; if (ififo_req !== 1'b0) begin errors++; $display("FAIL ififo_above_th got=%b exp=0", ififo_req); end
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h4) begin errors++; $display("FAIL start_int_done got=%h exp=4", rv); end
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h4) begin errors++; $display("FAIL start_status got=%h exp=4", rv); end
    wr(A_INT_STAT, 32'h4);
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL w1c_done got=%h exp=0", rv); end
  endtask

  task automatic test_watermark;
    ififo_cnt = 10'h040;
    checks++; if (ififo_req !== 1'b0) begin errors++; $display("FAIL ififo_req_latency got=%b exp=0", ififo_req); end
    step(1);
    checks++; if (ififo_req !== 1'b1) begin errors++; $display("FAIL ififo_req_at_th got=%b exp=1", ififo_req); end
    ififo_cnt = 10'h03F;
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h1) begin errors++; $display("FAIL ififo_int got=%h exp=1", rv); end
    wr(A_INT_STAT, 32'h1);
    step(2);
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL ififo_int_level got=%h exp=0", rv); end
    ofifo_cnt = 10'h0FF;
    step(1);
    checks++; if (ofifo_req !== 1'b0) begin errors++; $display("FAIL ofifo_below_th got=%b exp=0", ofifo_req); end
    ofifo_cnt = 10'h100;
    step(1);
    checks++; if (ofifo_req !== 1'b1) begin errors++; $display("FAIL ofifo_req_at_th got=%b exp=1", ofifo_req); end
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h2) begin errors++; $display("FAIL ofifo_int got=%h exp=2", rv); end
  endtask

  task automatic test_irq;
    wr(A_INT_STAT, 32'hF);
    ififo_cnt = 10'h041;
    step(2);
    checks++; if (ififo_req !== 1'b0) begin errors++; $display("FAIL ififo_req_drop got=%b exp=0", ififo_req); end
    ififo_cnt = 10'h040;
    step(1);
    wr(A_INT_EN, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got=%b exp=0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", irq); end
    wr(A_INT_STAT, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", irq); end
    step(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    ififo_cnt = 10'h041;
    step(2);
    ififo_cnt = 10'h040;
    wr(A_INT_STAT, 32'h1);
    checks++; if (ififo_req !== 1'b1) begin errors++; $display("FAIL collide_req got=%b exp=1", ififo_req); end
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h1) begin errors++; $display("FAIL set_beats_w1c got=%h exp=1", rv); end
  endtask

  task automatic test_srst_priority;
    wr(A_CTRL, 32'h6);
    checks++; if ({dec_rst, dec_en} !== 2'b10) begin errors++; $display("FAIL srst_outputs got=%b exp=10", {dec_rst, dec_en}); end
    checks++; if (ififo_req !== 1'b1) begin errors++; $display("FAIL req_lag got=%b exp=1", ififo_req); end
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h1) begin errors++; $display("FAIL srst_status got=%h exp=1", rv); end
    checks++; if (ififo_req !== 1'b0) begin errors++; $display("FAIL req_off_run got=%b exp=0", ififo_req); end
    n = 0;
    while (dec_rst === 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL srst_wait_timeout got=%0d exp<100", n); end
    step(1);
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h3) begin errors++; $display("FAIL srst_ready got=%h exp=3", rv); end
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL ready_dec_en got=%b exp=0", dec_en); end
    wr(A_CTRL, 32'h1);
    checks++; if (dec_en !== 1'b1) begin errors++; $display("FAIL ready_start got=%b exp=1", dec_en); end
    wr(A_CTRL, 32'h2);
    checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL run_stop got=%b exp=0", dec_en); end
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h3) begin errors++; $display("FAIL stop_status got=%h exp=3", rv); end
  endtask

  task automatic test_timeout;
    wr(A_INT_STAT, 32'hF);
    ififo_rst_busy = 1'b1;
    wr(A_CTRL, 32'h4);
    n = 0;
    while (dec_rst === 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_rst_assert_len got=%0d exp=16", n); end
    n = 0;
    while (dec_rst === 1'b0 && n < 2000) begin step(1); n++; end
    checks++; if (n !== 1023) begin errors++; $display("FAIL rst_wait_len got=%0d exp=1023", n); end
    checks++; if ({dec_rst, dec_en} !== 2'b10) begin errors++; $display("FAIL to_outputs got=%b exp=10", {dec_rst, dec_en}); end
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL to_status got=%h exp=0", rv); end
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h8) begin errors++; $display("FAIL to_int got=%h exp=8", rv); end
    ififo_rst_busy = 1'b0;
  endtask

  task automatic test_async_reset;
    wr(A_INT_EN, 32'h8);
    rd(A_THRESH, rv);
    wr(A_CTRL, 32'h1);
    step(5);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    checks++; if (reg_rdata !== 32'h0100_0040) begin errors++; $display("FAIL rdata_hold got=%h exp=01000040", reg_rdata); end
    #2; HRESETn = 1'b0; #1;
    checks++; if ({dec_rst, dec_en} !== 2'b10) begin errors++; $display("FAIL arst_dec got=%b exp=10", {dec_rst, dec_en}); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq got=%b exp=0", irq); end
    checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL arst_rdata got=%h exp=0", reg_rdata); end
    @(posedge HCLK); #1; HRESETn = 1'b1;
    rd(A_THRESH, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL arst_thresh got=%h exp=0", rv); end
    rd(A_INT_STAT, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL arst_int_stat got=%h exp=0", rv); end
    rd(A_INT_EN, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL arst_int_en got=%h exp=0", rv); end
    rd(A_STATUS, rv);
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL arst_status got=%h exp=0", rv); end
  endtask

  initial begin
    test_reset;
    test_regs;
    test_start;
    test_watermark;
    test_irq;
    test_srst_priority;
    test_timeout;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
